apb_mem_slave: RTL

APB completer with a word-addressed internal memory, sitting directly downstream of the APB master and answering its write and read transfers. It decodes the setup and access phases and inserts a configurable number of wait states. It returns read data or an error on PRDATA/PREADY/PSLVERR. Memory is register-based, sized by parameter.

---
 rtl/apb_mem_slave.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/apb_mem_slave.sv
// apb_mem_slave: APB completer backed by a register-based word memory, with WAIT_CYCLES wait states.
// Byte-lane write strobes (PSTRB) are present only when APB_MEM_PSTRB_EN is defined.
module apb_mem_slave #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_W-1:0]     PADDR,
    input  logic [DATA_W-1:0]     PWDATA,
`ifdef APB_MEM_PSTRB_EN
    input  logic [DATA_W/8-1:0]   PSTRB,
`endif
    output logic [DATA_W-1:0]     PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    output logic                  busy
);

    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [ADDR_W-1:0] DEPTH_A   = ADDR_W'(DEPTH);
    localparam logic [3:0]        WAIT_INIT = 4'(WAIT_CYCLES);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACCESS = 1'b1;

    logic [0:0]         state_q,   state_d;
    logic [3:0]         wait_q,    wait_d;
    logic [ADDR_W-1:0]  addr_q,    addr_d;
    logic               write_q,   write_d;
    logic [DATA_W-1:0]  wdata_q,   wdata_d;
    logic [STRB_W-1:0]  strb_q,    strb_d;
    logic [DATA_W-1:0]  prdata_q,  prdata_d;
    logic               pready_q,  pready_d;
    logic               pslverr_q, pslverr_d;
    logic               busy_q,    busy_d;

    logic [DATA_W-1:0]  mem_q [DEPTH];

    logic [STRB_W-1:0]  strb_in;
    logic [ADDR_W-1:0]  dec_addr;
    logic               dec_err;
    logic [IDX_W-1:0]   dec_idx;
    logic [DATA_W-1:0]  rd_word;
    logic [IDX_W-1:0]   wr_idx;
    logic [DATA_W-1:0]  wr_mask;
    logic               commit;

`ifdef APB_MEM_PSTRB_EN
    assign strb_in = PSTRB;
`else
    assign strb_in = '1;
`endif

    // With zero wait states the response is formed on the setup edge itself,
    // so decode the live bus address in IDLE and the latched one in ACCESS.
    assign dec_addr = (state_q == ST_IDLE) ? PADDR : addr_q;
    assign dec_err  = (dec_addr[1:0] != 2'b00) || ((dec_addr >> 2) >= DEPTH_A);
    assign dec_idx  = dec_addr[IDX_W+1:2];
    assign rd_word  = mem_q[dec_idx];

    assign wr_idx = addr_q[IDX_W+1:2];
    assign commit = (state_q == ST_ACCESS) && pready_q && PSEL && PENABLE
                    && write_q && !pslverr_q;

    for (genvar gi = 0; gi < STRB_W; gi++) begin : g_lane_mask
        assign wr_mask[gi*8 +: 8] = {8{strb_q[gi]}};
    end

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        addr_d    = addr_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        strb_d    = strb_q;
        prdata_d  = prdata_q;
        pready_d  = pready_q;
        pslverr_d = pslverr_q;
        busy_d    = busy_q;

        case (state_q)
            ST_IDLE: begin
                // PENABLE without a preceding setup is not a transfer.
                if (PSEL && !PENABLE) begin
                    addr_d  = PADDR;
                    write_d = PWRITE;
                    wdata_d = PWDATA;
                    strb_d  = strb_in;
                    wait_d  = WAIT_INIT;
                    state_d = ST_ACCESS;
                    busy_d  = 1'b1;
                    if (WAIT_INIT == 4'd0) begin
                        pready_d  = 1'b1;
                        pslverr_d = dec_err;
                        prdata_d  = (!PWRITE && !dec_err) ? rd_word : '0;
                    end
                end
            end

            ST_ACCESS: begin
                if (!PSEL) begin
                    state_d   = ST_IDLE;
                    wait_d    = 4'd0;
                    prdata_d  = '0;
                    pready_d  = 1'b0;
                    pslverr_d = 1'b0;
                    busy_d    = 1'b0;
                end else if (PENABLE) begin
                    if (pready_q) begin
                        state_d   = ST_IDLE;
                        prdata_d  = '0;
                        pready_d  = 1'b0;
                        pslverr_d = 1'b0;
                        busy_d    = 1'b0;
                    end else if (wait_q != 4'd0) begin
                        wait_d = wait_q - 4'd1;
                        if (wait_q == 4'd1) begin
                            pready_d  = 1'b1;
                            pslverr_d = dec_err;
                            prdata_d  = (!write_q && !dec_err) ? rd_word : '0;
                        end
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            wait_q    <= 4'd0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            strb_q    <= '0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            addr_q    <= addr_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            strb_q    <= strb_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            busy_q    <= busy_d;
        end
    end

    // Writes land only on the completion edge, merged per enabled byte lane.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int w = 0; w < DEPTH; w++) begin
                mem_q[w] <= '0;
            end
        end else if (commit) begin
            mem_q[wr_idx] <= (mem_q[wr_idx] & ~wr_mask) | (wdata_q & wr_mask);
        end
    end

    assign PRDATA  = prdata_q;
    assign PREADY  = pready_q;
    assign PSLVERR = pslverr_q;
    assign busy    = busy_q;

endmodule
